// File: rtl/vga_pkg.sv
// Shared VGA definitions: default data widths, the 4:4:4 colour type and the
// visible raster size shared with the sync generator.
package vga_pkg;

    localparam int RGB_BITS_DEF  = 12;
    localparam int PAL_BITS_DEF  = 8;
    localparam int ITER_BITS_DEF = 8;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Visible area of the sync generator's mode.
    localparam int HD = 1024;
    localparam int VD = 768;

    localparam rgb_t RGB_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};

endpackage

// File: rtl/vga_palette_ram.sv
// Dual-bank palette store: one write port, one registered read port.
// The bank is the address MSB, so the whole array maps onto a single block RAM.
module vga_palette_ram
    import vga_pkg::*;
#(
    parameter int PAL_BITS = PAL_BITS_DEF,
    parameter int RGB_BITS = RGB_BITS_DEF
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PAL_BITS:0]   waddr,
    input  logic [RGB_BITS-1:0] wdata,
    input  logic [PAL_BITS:0]   raddr,
    output logic [RGB_BITS-1:0] rdata
);

    localparam int DEPTH = 2 * (2 ** PAL_BITS);

    logic [RGB_BITS-1:0] mem [DEPTH];
    logic [RGB_BITS-1:0] rdata_d;
    logic [RGB_BITS-1:0] rdata_q;

    always_comb begin
        rdata_d = mem[raddr];
    end

    // No reset: contents and read register must stay RAM-mappable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// Frame-buffer read, palette lookup and sync/blank alignment stage after the
// VGA sync generator. Define VGA_PALETTE_CYCLE_EN for per-frame palette rotation.
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int X_PIXEL_N_BITS = 11,
    parameter int Y_PIXEL_N_BITS = 11,
    parameter int ADDR_BITS      = 20,
    parameter int ITER_BITS      = ITER_BITS_DEF,
    parameter int PAL_BITS       = PAL_BITS_DEF,
    parameter int RGB_BITS       = RGB_BITS_DEF,
    parameter int RD_LAT         = 2,
    parameter int MAX_ITER       = 255,
    parameter logic [RGB_BITS-1:0] SET_RGB = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      h_sync,
    input  logic                      v_sync,
    input  logic                      vga_on,
    input  logic                      border_on,
    input  logic                      h_blnk,
    input  logic                      v_blnk,
    input  logic [X_PIXEL_N_BITS-1:0] pixel_x,
    input  logic [Y_PIXEL_N_BITS-1:0] pixel_y,
    output logic                      fb_rd_en,
    output logic [ADDR_BITS-1:0]      fb_rd_addr,
    input  logic [ITER_BITS-1:0]      fb_rd_data,
    input  logic                      pal_we,
    input  logic [PAL_BITS-1:0]       pal_addr,
    input  logic [RGB_BITS-1:0]       pal_wdata,
    input  logic                      pal_swap,
    output logic                      pal_busy,
    input  logic                      cycle_en,
    output logic                      vga_hs,
    output logic                      vga_vs,
    output logic                      vga_blank,
    output logic [RGB_BITS-1:0]       vga_rgb
);

    localparam int L = RD_LAT + 3;

    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                 fb_rd_en_q, fb_rd_en_d;
    logic [ADDR_BITS-1:0] fb_rd_addr_q, fb_rd_addr_d;
    logic                 vs_q, vs_d;
    logic                 bank_sel_q, bank_sel_d;
    logic                 pend_q, pend_d;
    logic [L-1:0]         hs_dly_q, hs_dly_d;
    logic [L-1:0]         vs_dly_q, vs_dly_d;
    logic [L-1:0]         on_dly_q, on_dly_d;
    logic [L-1:0]         blank_dly_q, blank_dly_d;
    logic [L-1:0]         brd_dly_q, brd_dly_d;
    logic                 is_set_q, is_set_d;
    logic [RGB_BITS-1:0]  rgb_q, rgb_d;
    logic [PAL_BITS-1:0]  offset;
    logic [PAL_BITS-1:0]  rd_idx;
    logic [RGB_BITS-1:0]  pal_rdata;
    logic                 vs_rise;
    logic                 swap_now;

`ifdef VGA_PALETTE_CYCLE_EN
    logic [PAL_BITS-1:0]  offset_q, offset_d;
    assign offset = offset_q;
`else
    logic                 unused_cycle_en;
    assign unused_cycle_en = cycle_en;
    assign offset = '0;
`endif

    always_comb begin
        vs_rise  = v_sync & ~vs_q;
        // A request arriving on the rise itself is honoured at this boundary.
        swap_now = vs_rise & (pend_q | pal_swap);

        cnt_d = cnt_q;
        if (v_blnk) begin
            cnt_d = '0;
        end else if (vga_on) begin
            cnt_d = cnt_q + ADDR_BITS'(1);
        end

        fb_rd_en_d   = vga_on;
        fb_rd_addr_d = cnt_q;
        vs_d         = v_sync;
        bank_sel_d   = bank_sel_q ^ swap_now;
        pend_d       = swap_now ? 1'b0 : (pend_q | pal_swap);

        hs_dly_d    = {hs_dly_q[L-2:0], h_sync};
        vs_dly_d    = {vs_dly_q[L-2:0], v_sync};
        on_dly_d    = {on_dly_q[L-2:0], vga_on};
        blank_dly_d = {blank_dly_q[L-2:0], ~vga_on};
        brd_dly_d   = {brd_dly_q[L-2:0], border_on};

        rd_idx   = fb_rd_data[PAL_BITS-1:0] + offset;
        is_set_d = (fb_rd_data == ITER_BITS'(MAX_ITER));

        // Stage L-2 of the delay lines lines up with the palette read register.
        if (!on_dly_q[L-2]) begin
            rgb_d = '0;
        end else if (brd_dly_q[L-2]) begin
            rgb_d = RGB_BITS'(RGB_WHITE) | '1;
        end else if (is_set_q) begin
            rgb_d = SET_RGB;
        end else begin
            rgb_d = pal_rdata;
        end
`ifdef VGA_PALETTE_CYCLE_EN
        offset_d = offset_q + PAL_BITS'(vs_rise & cycle_en);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            fb_rd_en_q   <= 1'b0;
            fb_rd_addr_q <= '0;
            vs_q         <= 1'b0;
            bank_sel_q   <= 1'b0;
            pend_q       <= 1'b0;
            hs_dly_q     <= '0;
            vs_dly_q     <= '0;
            on_dly_q     <= '0;
            blank_dly_q  <= '0;
            brd_dly_q    <= '0;
            is_set_q     <= 1'b0;
            rgb_q        <= '0;
`ifdef VGA_PALETTE_CYCLE_EN
            offset_q     <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_rd_addr_q <= fb_rd_addr_d;
            vs_q         <= vs_d;
            bank_sel_q   <= bank_sel_d;
            pend_q       <= pend_d;
            hs_dly_q     <= hs_dly_d;
            vs_dly_q     <= vs_dly_d;
            on_dly_q     <= on_dly_d;
            blank_dly_q  <= blank_dly_d;
            brd_dly_q    <= brd_dly_d;
            is_set_q     <= is_set_d;
            rgb_q        <= rgb_d;
`ifdef VGA_PALETTE_CYCLE_EN
            offset_q     <= offset_d;
`endif
        end
    end

    vga_palette_ram #(
        .PAL_BITS (PAL_BITS),
        .RGB_BITS (RGB_BITS)
    ) u_pal (
        .clk   (clk),
        .we    (pal_we),
        .waddr ({~bank_sel_q, pal_addr}),
        .wdata (pal_wdata),
        .raddr ({bank_sel_q, rd_idx}),
        .rdata (pal_rdata)
    );

    assign fb_rd_en   = fb_rd_en_q;
    assign fb_rd_addr = fb_rd_addr_q;
    assign pal_busy   = pend_q;
    assign vga_hs     = hs_dly_q[L-1];
    assign vga_vs     = vs_dly_q[L-1];
    assign vga_blank  = blank_dly_q[L-1];
    assign vga_rgb    = rgb_q;

    a_on_in_visible: assert property (@(posedge clk) disable iff (rst)
        vga_on |-> (pixel_x < X_PIXEL_N_BITS'(HD)) && (pixel_y < Y_PIXEL_N_BITS'(VD))
                   && !h_blnk && !v_blnk);

    a_addr_in_frame: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= ADDR_BITS'(HD * VD - 1));

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe on a miniature 8x4 visible raster
// (12x7 total) driven from a simple raster generator.
module tb_vga_pixel_pipe;

    localparam int RD_LAT = 2;
    localparam int L      = RD_LAT + 3;
    localparam int HV = 8, HT = 12, VV = 4, VT = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_sync, v_sync, vga_on, border_on, h_blnk, v_blnk;
    logic [10:0] pixel_x, pixel_y;
    logic        fb_rd_en;
    logic [19:0] fb_rd_addr;
    logic [7:0]  fb_rd_data;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic        pal_swap, pal_busy, cycle_en;
    logic        vga_hs, vga_vs, vga_blank;
    logic [11:0] vga_rgb;

    always #5 clk = ~clk;

    vga_pixel_pipe #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .h_sync(h_sync), .v_sync(v_sync), .vga_on(vga_on), .border_on(border_on),
        .h_blnk(h_blnk), .v_blnk(v_blnk), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .pal_swap(pal_swap), .pal_busy(pal_busy), .cycle_en(cycle_en),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank), .vga_rgb(vga_rgb)
    );

    // Frame-buffer model with RD_LAT cycles of read latency.
    logic [7:0] fbmem [1024];
    logic [7:0] fb_pipe [RD_LAT];
    always @(posedge clk) begin
        fb_pipe[0] <= fb_rd_en ? fbmem[fb_rd_addr[9:0]] : 8'h00;
        for (int i = 1; i < RD_LAT; i++) fb_pipe[i] <= fb_pipe[i-1];
    end
    assign fb_rd_data = fb_pipe[RD_LAT-1];

    typedef struct {
        logic        hs, vs, blank;
        logic [11:0] rgb;
        bit          sync_ok, rgb_ok;
    } ent_t;

    ent_t        hist [16];
    int          n = 0;
    int          hx = 0, vy = 0;
    int          checks = 0, errors = 0;
    bit          border_mode = 0, rgb_chk = 0;
    int          exp_off = 0;
    logic [11:0] exp_pal [256];
    logic        drv_rst = 1'b1, drv_swap = 1'b0, drv_we = 1'b0, drv_cycle = 1'b0;
    logic [7:0]  drv_waddr = '0;
    logic [11:0] drv_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit on, input bit brd);
        logic [7:0] d;
        if (!on) return 12'h000;
        if (brd) return 12'hFFF;
        d = fbmem[y * HV + x];
        if (d == 8'd255) return 12'h000;
        return exp_pal[(int'(d) + exp_off) % 256];
    endfunction

    // Drive one raster position, clock it, then compare the entry L-1 edges old.
    task automatic step();
        ent_t e;
        bit   on;
        on        = (hx < HV) && (vy < VV);
        rst       = drv_rst;
        vga_on    = on;
        h_blnk    = (hx >= HV);
        v_blnk    = (vy >= VV);
        h_sync    = (hx == 9) || (hx == 10);
        v_sync    = (vy == 5);
        border_on = border_mode && on && (hx == 0 || hx == HV-1 || vy == 0 || vy == VV-1);
        pixel_x   = 11'(hx);
        pixel_y   = 11'(vy);
        pal_we    = drv_we;
        pal_addr  = drv_waddr;
        pal_wdata = drv_wdata;
        pal_swap  = drv_swap;
        cycle_en  = drv_cycle;
        e.hs      = h_sync;
        e.vs      = v_sync;
        e.blank   = !on;
        e.rgb     = exp_rgb(hx, vy, on, border_on);
        e.sync_ok = !drv_rst;
        e.rgb_ok  = rgb_chk && !drv_rst;
        if (drv_rst) begin
            for (int i = 0; i < 16; i++) begin
                hist[i].sync_ok = 1'b0;
                hist[i].rgb_ok  = 1'b0;
            end
        end
        hist[n % 16] = e;
        @(posedge clk);
        #1;
        if (n >= L - 1) begin
            e = hist[(n - (L - 1)) % 16];
            if (e.sync_ok) begin
                chk("vga_hs", 32'(vga_hs), 32'(e.hs));
                chk("vga_vs", 32'(vga_vs), 32'(e.vs));
                chk("vga_blank", 32'(vga_blank), 32'(e.blank));
            end
            if (e.rgb_ok) chk("vga_rgb", 32'(vga_rgb), 32'(e.rgb));
        end
        n++;
        hx++;
        if (hx == HT) begin hx = 0; vy++; end
        if (vy == VT) vy = 0;
    endtask

    task automatic run_to(input int x, input int y);
        int guard = 0;
        while (!(hx == x && vy == y)) begin
            step();
            guard++;
            if (guard > 2 * HT * VT) begin
                errors++;
                $error("FAIL run_to_timeout observed=%0d,%0d expected=%0d,%0d", hx, vy, x, y);
                return;
            end
        end
    endtask

    task automatic run_n(input int cnt);
        for (int i = 0; i < cnt; i++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hs"}, 32'(vga_hs), 0);
        chk({tag, "_vs"}, 32'(vga_vs), 0);
        chk({tag, "_blank"}, 32'(vga_blank), 0);
        chk({tag, "_rgb"}, 32'(vga_rgb), 0);
        chk({tag, "_busy"}, 32'(pal_busy), 0);
        chk({tag, "_rd_en"}, 32'(fb_rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(fb_rd_addr), 0);
    endtask

    task automatic load_shadow(input logic [11:0] base, input bit ramp);
        for (int i = 0; i < 256; i++) begin
            drv_we    = 1'b1;
            drv_waddr = 8'(i);
            drv_wdata = ramp ? 12'(i) : base;
            step();
        end
        drv_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) fbmem[i] = 8'(i);

        // Reset while the raster runs through visible pixels.
        run_n(3);
        chk_all_zero("reset");
        drv_rst = 1'b0;

        // Identity palette into the shadow bank, then swap mid-frame.
        load_shadow(12'h000, 1'b1);
        run_to(2, 1);
        drv_swap = 1'b1;
        step();
        drv_swap = 1'b0;
        chk("swap1_busy_set", 32'(pal_busy), 1);
        run_to(0, 6);
        chk("swap1_busy_clr", 32'(pal_busy), 0);
        for (int i = 0; i < 256; i++) exp_pal[i] = 12'(i);
        rgb_chk = 1;
        run_n(2 * HT * VT);

        // Inside-set data everywhere with a border.
        run_to(0, 6);
        for (int i = 0; i < 1024; i++) fbmem[i] = 8'd255;
        border_mode = 1;
        run_n(HT * VT);
        run_to(0, 6);
        for (int i = 0; i < 1024; i++) fbmem[i] = 8'(i);
        border_mode = 0;

        // Red shadow bank; colours hold until the v_sync rise.
        load_shadow(12'hF00, 1'b0);
        run_to(3, 1);
        drv_swap = 1'b1;
        step();
        drv_swap = 1'b0;
        chk("swap2_busy_set", 32'(pal_busy), 1);
        drv_swap = 1'b1;
        step();
        drv_swap = 1'b0;
        chk("swap2_repeat_busy", 32'(pal_busy), 1);
        run_to(0, 5);
        chk("swap2_busy_hold", 32'(pal_busy), 1);
        step();
        chk("swap2_busy_clr", 32'(pal_busy), 0);
        for (int i = 0; i < 256; i++) exp_pal[i] = 12'hF00;
        run_n(HT * VT);

        // Swap requested on the v_sync rising cycle itself.
        run_to(0, 5);
        drv_swap = 1'b1;
        step();
        drv_swap = 1'b0;
        for (int i = 0; i < 256; i++) exp_pal[i] = 12'(i);
        for (int i = 0; i < 4; i++) begin
            chk("swap3_busy_low", 32'(pal_busy), 0);
            step();
        end
        run_n(HT * VT);

`ifdef VGA_PALETTE_CYCLE_EN
        // Rotation: one boundary gives +1, 256 boundaries wrap back to 0.
        run_to(0, 5);
        drv_cycle = 1'b1;
        step();
        drv_cycle = 1'b0;
        exp_off = 1;
        run_n(HT * VT);
        rgb_chk = 0;
        for (int f = 0; f < 255; f++) begin
            run_to(0, 5);
            drv_cycle = 1'b1;
            step();
            drv_cycle = 1'b0;
        end
        exp_off = 0;
        rgb_chk = 1;
        run_n(HT * VT);
`endif

        // Reset mid-line: bank 0 (red) becomes active again.
        run_to(3, 1);
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        chk_all_zero("midreset");
        rgb_chk = 0;
        exp_off = 0;
        for (int i = 0; i < 256; i++) exp_pal[i] = 12'hF00;
        run_to(0, 6);
        rgb_chk = 1;
        run_to(0, 0);
        step();
        chk("realign_rd_en", 32'(fb_rd_en), 1);
        chk("realign_addr0", 32'(fb_rd_addr), 0);
        step();
        chk("realign_addr1", 32'(fb_rd_addr), 1);
        run_n(HT * VT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
